// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-way round-robin select arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [N_REQ-1:0] sel_onehot(input sel_t s);
    return N_REQ'(1) << s;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority scan: returns the first eligible requester at or after ptr.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  sel_t             ptr,
  output sel_t             idx,
  output logic             any
);

  logic [N_REQ-1:0] eligible;
  sel_t             cand;

  always_comb begin
    eligible = req & ~mask;
    any      = |eligible;
    idx      = ptr;
    cand     = ptr;
    // Walk from the farthest offset down so the nearest eligible source wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = sel_t'(ptr + sel_t'(i));
      if (eligible[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing the registered 2-bit select and one-hot grant for a 4:1 mux.
module rr_sel_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             valid
);

  arb_state_t       state_q;
  sel_t             ptr_q;
  sel_t             sel_q;
  logic [N_REQ-1:0] grant_q;
  logic             valid_q;
  logic [CNT_W-1:0] hold_cnt_q;

  logic             hold_exp;
  logic             release_c;
  sel_t             pick_ptr;
  logic [N_REQ-1:0] pick_mask;
  sel_t             pick_idx;
  logic             pick_any;

  assign hold_exp  = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
  assign release_c = done | ~req[sel_q] | hold_exp;

  // One picker serves both the idle pick and the release re-pick; a source
  // that signalled done is excluded from the re-pick it triggered.
  always_comb begin
    pick_ptr  = ptr_q;
    pick_mask = '0;
    if (state_q == BUSY) begin
      pick_ptr = sel_t'(sel_q + sel_t'(1));
      if (done) begin
        pick_mask = sel_onehot(sel_q);
      end
    end
  end

  rr_pick4 u_pick (
    .req  (req),
    .mask (pick_mask),
    .ptr  (pick_ptr),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q    <= BUSY;
            sel_q      <= pick_idx;
            grant_q    <= sel_onehot(pick_idx);
            valid_q    <= 1'b1;
            hold_cnt_q <= '0;
          end
        end
        BUSY: begin
          if (!release_c) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end else begin
            ptr_q <= pick_ptr;
            if (pick_any) begin
              sel_q      <= pick_idx;
              grant_q    <= sel_onehot(pick_idx);
              valid_q    <= 1'b1;
              hold_cnt_q <= '0;
            end else begin
              // Nobody left: go idle but keep sel pointing at the last owner.
              state_q <= IDLE;
              grant_q <= '0;
              valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter (HOLD_MAX=4) with an expectation queue per step.
module tb_rr_sel_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    string      tag;
  } exp_t;

  exp_t sb[$];

  rr_sel_arbiter #(
    .HOLD_MAX (4),
    .CNT_W    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .done  (done),
    .sel   (sel),
    .grant (grant),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, record what the next edge must produce, then check it.
  task automatic step(input logic r_rst, input logic [3:0] r_req, input logic r_done,
                      input logic [1:0] es, input logic [3:0] eg, input logic ev,
                      input string tag);
    exp_t e;
    exp_t got;
    e.sel   = es;
    e.grant = eg;
    e.valid = ev;
    e.tag   = tag;
    reset   = r_rst;
    req     = r_req;
    done    = r_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    n_checks++;
    assert (sel === got.sel) else begin
      n_fail++;
      $error("FAIL %s sel got %0d expected %0d", got.tag, sel, got.sel);
    end
    n_checks++;
    assert (grant === got.grant) else begin
      n_fail++;
      $error("FAIL %s grant got %b expected %b", got.tag, grant, got.grant);
    end
    n_checks++;
    assert (valid === got.valid) else begin
      n_fail++;
      $error("FAIL %s valid got %b expected %b", got.tag, valid, got.valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    done  = 1'b0;

    // 1: reset with all requesting, then first grant goes to source 0
    step(1'b1, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, "rst0");
    step(1'b1, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, "rst1");
    step(1'b0, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, "first");

    // 2: done every third cycle rotates 0->1->2->3->0
    for (int o = 0; o < 4; o++) begin
      logic [1:0] cur;
      logic [1:0] nxt;
      cur = 2'(o);
      nxt = 2'(o + 1);
      step(1'b0, 4'b1111, 1'b0, cur, 4'(1 << cur), 1'b1, "rot_hold");
      step(1'b0, 4'b1111, 1'b0, cur, 4'(1 << cur), 1'b1, "rot_hold");
      step(1'b0, 4'b1111, 1'b1, nxt, 4'(1 << nxt), 1'b1, "rot_next");
    end

    // 3: hold expiry alternates between 0 and 2, four cycles each
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0101, 1'b0, 2'd0, 4'b0001, 1'b1, "hold_o0");
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0101, 1'b0, 2'd2, 4'b0100, 1'b1, "hold_o2");
    step(1'b0, 4'b0101, 1'b0, 2'd0, 4'b0001, 1'b1, "hold_back0");
    // sole requester keeps the line across forced rotations
    for (int i = 0; i < 11; i++) step(1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, "sole");

    // 4: sparse request, drop to idle with sel held, then ptr wrapped to 0
    step(1'b0, 4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1, "sparse3");
    step(1'b0, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, "idle_a");
    step(1'b0, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, "idle_b");
    step(1'b0, 4'b1001, 1'b0, 2'd0, 4'b0001, 1'b1, "wrap_ptr0");

    // 5: done coincides with hold expiry for the only requester
    step(1'b0, 4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, "own1");
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, "own1_hold");
    step(1'b0, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, "done_exp_idle");
    step(1'b0, 4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, "regrant1");

    // 6: reset mid-grant, then ptr restarts at 0
    step(1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, "own2");
    step(1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, "own2_h1");
    step(1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, "own2_h2");
    step(1'b1, 4'b0100, 1'b0, 2'd0, 4'b0000, 1'b0, "mid_rst");
    step(1'b0, 4'b1100, 1'b0, 2'd2, 4'b0100, 1'b1, "post_rst");
    step(1'b0, 4'b1100, 1'b1, 2'd3, 4'b1000, 1'b1, "post_rst_next");

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard leftover got %0d expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
